// File: rtl/iniciador_banco.sv
// Request sequencer for the 32x32 register bank: turns read/write/write-then-read requests into bank strobes.
// Optional build macro REG0_ZERO_EN makes register 0 read as zero and ignore writes.
module iniciador_banco #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_ra,
  input  logic [ADDR_W-1:0] req_rb,
  input  logic [ADDR_W-1:0] req_rw,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_a,
  output logic [DATA_W-1:0] rsp_b,
  output logic              err,
  output logic [ADDR_W-1:0] dir_a,
  output logic [ADDR_W-1:0] dir_b,
  output logic [ADDR_W-1:0] dir_wra,
  output logic [DATA_W-1:0] di,
  output logic              reg_rd,
  output logic              reg_wr,
  input  logic [DATA_W-1:0] doa,
  input  logic [DATA_W-1:0] dob
);

`ifdef REG0_ZERO_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_WRRD = 2'b10;

  // Extra wait cycles after the read strobe cycle before doa/dob can be captured.
  localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_WAIT, S_RSP} state_t;

  state_t              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                err_q, err_d;
  logic                reg_rd_q, reg_rd_d;
  logic                reg_wr_q, reg_wr_d;
  logic [ADDR_W-1:0]   dir_a_q, dir_a_d;
  logic [ADDR_W-1:0]   dir_b_q, dir_b_d;
  logic [ADDR_W-1:0]   dir_wra_q, dir_wra_d;
  logic [DATA_W-1:0]   di_q, di_d;
  logic [DATA_W-1:0]   rsp_a_q, rsp_a_d;
  logic [DATA_W-1:0]   rsp_b_q, rsp_b_d;
  logic [ADDR_W-1:0]   ra_q, ra_d;
  logic [ADDR_W-1:0]   rb_q, rb_d;
  logic                wrrd_q, wrrd_d;
  logic [1:0]          cnt_q, cnt_d;

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    err_d       = err_q;
    reg_rd_d    = 1'b0;
    reg_wr_d    = 1'b0;
    dir_a_d     = dir_a_q;
    dir_b_d     = dir_b_q;
    dir_wra_d   = dir_wra_q;
    di_d        = di_q;
    rsp_a_d     = rsp_a_q;
    rsp_b_d     = rsp_b_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    wrrd_d      = wrrd_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          ra_d   = req_ra;
          rb_d   = req_rb;
          wrrd_d = (req_op == OP_WRRD);
          if (req_op == OP_RD) begin
            dir_a_d     = req_ra;
            dir_b_d     = req_rb;
            reg_rd_d    = 1'b1;
            req_ready_d = 1'b0;
            state_d     = S_RD;
          end else if (req_op == OP_WR || req_op == OP_WRRD) begin
            dir_wra_d   = req_rw;
            di_d        = req_wdata;
            reg_wr_d    = !(ZERO_EN && req_rw == '0);
            req_ready_d = 1'b0;
            state_d     = S_WR;
          end else begin
            // Reserved op: consumed in place, only the sticky error records it.
            err_d = 1'b1;
          end
        end
      end
      S_WR: begin
        if (wrrd_q) begin
          dir_a_d  = ra_q;
          dir_b_d  = rb_q;
          reg_rd_d = 1'b1;
          state_d  = S_RD;
        end else begin
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_RD: begin
        cnt_d   = WAIT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          // dir_a/dir_b still hold the addresses of this read.
          rsp_a_d     = (ZERO_EN && dir_a_q == '0) ? '0 : doa;
          rsp_b_d     = (ZERO_EN && dir_b_q == '0) ? '0 : dob;
          rsp_valid_d = 1'b1;
          state_d     = S_RSP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      reg_rd_q    <= 1'b0;
      reg_wr_q    <= 1'b0;
      dir_a_q     <= '0;
      dir_b_q     <= '0;
      dir_wra_q   <= '0;
      di_q        <= '0;
      rsp_a_q     <= '0;
      rsp_b_q     <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      wrrd_q      <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of every other flop.
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
      reg_rd_q    <= reg_rd_d;
      reg_wr_q    <= reg_wr_d;
      dir_a_q     <= dir_a_d;
      dir_b_q     <= dir_b_d;
      dir_wra_q   <= dir_wra_d;
      di_q        <= di_d;
      rsp_a_q     <= rsp_a_d;
      rsp_b_q     <= rsp_b_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      wrrd_q      <= wrrd_d;
      cnt_q       <= cnt_d;
    end
  end

  // Ready is held low throughout reset, even before the first reset edge.
  assign req_ready = req_ready_q & rst_n;
  assign rsp_valid = rsp_valid_q;
  assign rsp_a     = rsp_a_q;
  assign rsp_b     = rsp_b_q;
  assign err       = err_q;
  assign dir_a     = dir_a_q;
  assign dir_b     = dir_b_q;
  assign dir_wra   = dir_wra_q;
  assign di        = di_q;
  assign reg_rd    = reg_rd_q;
  assign reg_wr    = reg_wr_q;

endmodule

// File: tb/tb_iniciador_banco.sv
// Bench for iniciador_banco: behavioural bank with one-edge read latency, reference register model and response scoreboard.
`timescale 1ns/1ps
module tb_iniciador_banco;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_WRRD = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;
`ifdef REG0_ZERO_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic          clk, rst_n;
  logic          req_valid, req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_ra, req_rb, req_rw;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_a, rsp_b;
  logic          err;
  logic [AW-1:0] dir_a, dir_b, dir_wra;
  logic [DW-1:0] di, doa, dob;
  logic          reg_rd, reg_wr;

  iniciador_banco #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_ra(req_ra), .req_rb(req_rb), .req_rw(req_rw), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_a(rsp_a), .rsp_b(rsp_b),
    .err(err), .dir_a(dir_a), .dir_b(dir_b), .dir_wra(dir_wra), .di(di),
    .reg_rd(reg_rd), .reg_wr(reg_wr), .doa(doa), .dob(dob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register bank: read data appears one edge after reg_rd is sampled.
  logic          bank_clr;
  logic [DW-1:0] bank [32];
  always @(posedge clk) begin
    if (bank_clr) begin
      for (int i = 0; i < 32; i++) bank[i] <= '0;
    end else begin
      if (reg_wr) bank[dir_wra] <= di;
      if (reg_rd) begin
        doa <= bank[dir_a];
        dob <= bank[dir_b];
      end
    end
  end

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } rsp_t;

  rsp_t          exp_q[$];
  logic [DW-1:0] ref_mem [32];
  int            n_checks = 0;
  int            n_pass = 0;
  int            wr_hi = 0;
  int            rd_hi = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  always @(negedge clk) begin
    rsp_t e;
    if (reg_rd && reg_wr) check("strobe_overlap", {reg_rd, reg_wr}, 2'b00);
    if (reg_wr) wr_hi++;
    if (reg_rd) rd_hi++;
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", rsp_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_a", rsp_a, e.a);
        check("rsp_b", rsp_b, e.b);
      end
    end
  end

  // Drives one request, returns the cycle of the accepting edge; inputs are scrambled afterwards.
  task automatic send(input logic [1:0] op, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                      input logic [AW-1:0] rw, input logic [DW-1:0] wd, output int acc);
    int   t;
    rsp_t e;
    @(negedge clk);
    req_op = op; req_ra = ra; req_rb = rb; req_rw = rw; req_wdata = wd; req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("accept_timeout", req_ready, 1'b1);
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid = 1'b0;
    req_ra = 5'($urandom); req_rb = 5'($urandom); req_rw = 5'($urandom); req_wdata = $urandom;
    if ((op == OP_WR || op == OP_WRRD) && !(ZERO && rw == '0)) ref_mem[rw] = wd;
    if (op == OP_RD || op == OP_WRRD) begin
      e.a = (ZERO && ra == '0) ? '0 : ref_mem[ra];
      e.b = (ZERO && rb == '0) ? '0 : ref_mem[rb];
      exp_q.push_back(e);
    end
    case (op)
      OP_RD: begin
        check("rd_strobe", reg_rd, 1'b1);
        check("rd_dir_a", dir_a, ra);
        check("rd_dir_b", dir_b, rb);
        check("rd_no_wr", reg_wr, 1'b0);
        check("rd_busy", req_ready, 1'b0);
      end
      OP_WR, OP_WRRD: begin
        check("wr_strobe", reg_wr, (ZERO && rw == '0) ? 1'b0 : 1'b1);
        check("wr_dir_wra", dir_wra, rw);
        check("wr_di", di, wd);
        check("wr_no_rd", reg_rd, 1'b0);
        check("wr_busy", req_ready, 1'b0);
      end
      default: begin
        check("rsv_err", err, 1'b1);
        check("rsv_no_strobe", {reg_rd, reg_wr}, 2'b00);
        check("rsv_ready", req_ready, 1'b1);
      end
    endcase
  endtask

  task automatic wait_rsp(input int acc, input int lat);
    int t = 0;
    @(negedge clk);
    while (!rsp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("rsp_timeout", rsp_valid, 1'b1);
    else check("rsp_latency", cyc - acc, lat);
  endtask

  initial begin
    int a0, a1, a2, acc, w0, r0;
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_ra = '0; req_rb = '0; req_rw = '0;
    req_wdata = '0; rsp_ready = 1'b1; bank_clr = 1'b1;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1 bank_clr = 1'b0;

    @(negedge clk);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_strobes", {reg_rd, reg_wr}, 2'b00);
    check("rst_err", err, 1'b0);
    check("rst_dirs", {dir_a, dir_b, dir_wra}, 15'd0);
    check("rst_di", di, 32'd0);
    check("rst_rsp", {rsp_a, rsp_b}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", req_ready, 1'b1);

    // Back-to-back writes: one accept every two cycles, one-cycle pulses.
    w0 = wr_hi;
    send(OP_WR, 0, 0, 10, 2, a0);
    send(OP_WR, 0, 0, 11, 5, a1);
    check("wr_spacing_1", a1 - a0, 2);
    send(OP_WR, 0, 0, 12, 20, a2);
    check("wr_spacing_2", a2 - a1, 2);
    repeat (2) @(posedge clk);
    #1;
    check("wr_pulse_cycles", wr_hi - w0, 3);
    check("wr_dropped", reg_wr, 1'b0);

    // Plain read.
    r0 = rd_hi;
    send(OP_RD, 10, 12, 0, 0, acc);
    wait_rsp(acc, 2);
    @(posedge clk); #1;
    check("rd_pulse_cycles", rd_hi - r0, 1);

    // Write-then-read with a stalled consumer.
    rsp_ready = 1'b0;
    send(OP_WRRD, 10, 12, 10, 50, acc);
    @(posedge clk); #1;
    check("wrrd_rd_strobe", reg_rd, 1'b1);
    check("wrrd_dirs", {dir_a, dir_b}, {5'd10, 5'd12});
    check("wrrd_wr_dropped", reg_wr, 1'b0);
    wait_rsp(acc, 3);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_a", rsp_a, 32'd50);
      check("hold_b", rsp_b, 32'd20);
      check("hold_ready", req_ready, 1'b0);
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("rsp_released", rsp_valid, 1'b0);
    check("ready_after_rsp", req_ready, 1'b1);

    // Reserved ops and sticky error.
    send(OP_RSV, 1, 2, 3, 32'hdead_beef, acc);
    repeat (10) @(posedge clk);
    #1;
    check("err_sticky", err, 1'b1);
    send(OP_RSV, 4, 5, 6, 32'h1234_5678, acc);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("err_cleared", err, 1'b0);
    check("ready_in_rst", req_ready, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_err_rst", req_ready, 1'b1);

    // Reset while a read waits for bank data: request and response are abandoned.
    send(OP_RD, 11, 10, 0, 0, acc);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check("mid_rst_valid", rsp_valid, 1'b0);
    check("mid_rst_strobes", {reg_rd, reg_wr}, 2'b00);
    check("mid_rst_ready", req_ready, 1'b0);
    check("mid_rst_dirs", {dir_a, dir_b, dir_wra}, 15'd0);
    check("mid_rst_rsp", {rsp_a, rsp_b}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_release", req_ready, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("mid_rst_no_rsp", rsp_valid, 1'b0);

    // Address 0: ordinary register by default, hard zero with REG0_ZERO_EN.
    send(OP_WR, 0, 0, 0, 7, acc);
    send(OP_RD, 0, 11, 0, 0, acc);
    wait_rsp(acc, 2);
    @(posedge clk); #1;

    // Random mix over a small address window.
    for (int i = 0; i < 10; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 2));
      send(op, 5'(8 + $urandom_range(0, 7)), 5'(8 + $urandom_range(0, 7)),
           5'(8 + $urandom_range(0, 7)), $urandom, acc);
      if (op != OP_WR) begin
        wait_rsp(acc, (op == OP_RD) ? 2 : 3);
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/iniciador_banco.md
# iniciador_banco

Request sequencer that drives the 32x32 register bank (`BancoRegistros`) from the datapath side. It accepts read, write and write-then-read requests over a valid/ready handshake and sequences the bank's `dir_a`/`dir_b`/`dir_wra`/`di`/`reg_rd`/`reg_wr` controls. It captures `doa`/`dob` after the bank's read latency and returns them over a valid/ready response channel. It sits between the control unit and the register bank, so the control unit never times bank strobes directly.

## Interface
- `DATA_W`, 32, data width of bank words
- `ADDR_W`, 5, register address width
- `RD_LAT`, 1, edges from `reg_rd` sampled to `doa`/`dob` valid; legal range is 1 to 4
- `clk` in 1: single clock; all logic updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when this and `req_valid` are both high at an edge.
- `req_op` in 2: operation code; 00 READ, 01 WRITE, 10 WRITE_READ, 11 reserved.
- `req_ra` in ADDR_W: read address for port A.
- `req_rb` in ADDR_W: read address for port B.
- `req_rw` in ADDR_W: write address.
- `req_wdata` in DATA_W: write data.
- `rsp_valid` out 1: response data held stable on `rsp_a`/`rsp_b` until `rsp_ready`.
- `rsp_ready` in 1: response consumer ready.
- `rsp_a` out DATA_W: port-A read result.
- `rsp_b` out DATA_W: port-B read result.
- `err` out 1: sticky flag, set when a reserved op is accepted; cleared only by reset.
- `dir_a` out ADDR_W: bank port-A address.
- `dir_b` out ADDR_W: bank port-B address.
- `dir_wra` out ADDR_W: bank write address.
- `di` out DATA_W: bank write data.
- `reg_rd` out 1: bank read strobe.
- `reg_wr` out 1: bank write strobe.
- `doa` in DATA_W: bank port-A data.
- `dob` in DATA_W: bank port-B data.

## Operation
- States and transitions:
  - IDLE: `req_ready`=1. On accept, go to WR (ops 01, 10), RD (op 00) or stay in IDLE (op 11, which also sets `err`).
  - WR: one cycle with `reg_wr`=1, `dir_wra`=`req_rw`, `di`=`req_wdata`. Next state is IDLE for WRITE, RD for WRITE_READ.
  - RD: one cycle with `reg_rd`=1, `dir_a`=`req_ra`, `dir_b`=`req_rb`. Next state is WAIT.
  - WAIT: counts RD_LAT-1 cycles (zero cycles when RD_LAT=1). On the final edge, capture `doa`→`rsp_a` and `dob`→`rsp_b`, then go to RSP.
  - RSP: `rsp_valid`=1. On `rsp_ready`, go to IDLE.
- Request fields are latched at accept; later changes to the inputs have no effect.
- All bank-side outputs are registered. `reg_rd` and `reg_wr` are never high in the same cycle.
- Outside their strobe cycles, addresses and `di` hold their last driven values.
- WRITE_READ returns the post-write contents. A read of `req_rw` returns `req_wdata`, because the write edge precedes the read edge.
- WRITE produces no response.
- `req_ready` is 0 in every state except IDLE, so there is only one outstanding request.

## Timing
- Reset (`rst_n`=0 at an edge): state goes to IDLE. `req_ready`, `rsp_valid`, `reg_rd`, `reg_wr` and `err` are 0. `dir_a`, `dir_b`, `dir_wra`, `di`, `rsp_a` and `rsp_b` are 0.
- `req_ready` is forced to 0 while `rst_n`=0.
- Reset mid-operation abandons the request and drops any pending response. Strobes are low in the cycle after the reset edge.
- READ accepted at edge N:
  - `reg_rd` is high in cycle N..N+1.
  - `rsp_valid` rises at edge N+1+RD_LAT, i.e. 2 cycles for RD_LAT=1.
- WRITE accepted at edge N:
  - `reg_wr` is high in cycle N..N+1.
  - `req_ready` returns at edge N+1, giving a back-to-back write rate of one per 2 cycles.
- WRITE_READ: `rsp_valid` rises at edge N+2+RD_LAT.
- `rsp_valid` held with `rsp_ready`=0: `rsp_a`/`rsp_b` stay stable indefinitely, and no new request is accepted.
- `rsp_ready` high in the first RSP cycle: IDLE at the next edge. A new request can then be accepted the following edge.
- Simultaneous reserved op and error: `err` rises at the accept edge. A second reserved op leaves `err` high.

## Configuration
- `REG0_ZERO_EN` defined:
  - Writes to address 0 are suppressed: the WR cycle still occurs, but `reg_wr` stays 0.
  - A read with `req_ra`=0 forces `rsp_a`=0, and with `req_rb`=0 forces `rsp_b`=0, regardless of `doa`/`dob`.
- Undefined: address 0 is an ordinary register.

## Test plan
- Reset, then WRITE r10=2, r11=5, r12=20 back-to-back → `reg_wr` pulses 1 cycle each, 2 cycles apart. `dir_wra`/`di` match the request in each pulse.
- READ ra=10, rb=12 → `reg_rd` for 1 cycle; `rsp_valid` 2 cycles after accept with `rsp_a`=2, `rsp_b`=20.
- WRITE_READ rw=10, wdata=50, ra=10, rb=12 → `rsp_a`=50, `rsp_b`=20. Hold `rsp_ready`=0 for 5 cycles: `rsp_valid`/data stable and `req_ready`=0 throughout.
- Reserved op 11 → accepted in one cycle, no strobes, `err`=1 and still set after 10 idle cycles. Reset clears it.
- Assert `rst_n`=0 in the WAIT/RSP cycle of a READ → no `rsp_valid`. All outputs are 0 next cycle, and `req_ready`=1 one cycle after release.
- With `REG0_ZERO_EN`: WRITE r0=7 leaves `reg_wr`=0. READ ra=0, rb=11 gives `rsp_a`=0, `rsp_b`=5.
